md_issue_ctrl: RTL and testbench

- Initiator side of the multiply/divide unit interface, placed in the E stage beside the MDU.
- Takes the decoded MD operation of the instruction in E and drives the MDU command bus (enable, opcode, operands).
- Keeps a cycle-exact shadow of the MDU busy window and raises the pipeline stall for any MD-class instruction that meets a busy unit.
- Cross-checks the MDU's busy output against its own prediction and flags any mismatch.

---
 rtl/md_issue_ctrl_pkg.sv | 46 ++++
 rtl/md_busy_shadow.sv | 52 +++++
 rtl/md_issue_ctrl.sv | 77 +++++++
 tb/tb_md_issue_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the MD issue controller: MD opcode values (identical
// to what the MDU decodes), op-class decode helpers and the shadow FSM states.
package md_issue_ctrl_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } md_state_e;

  // START ops kick off a multi-cycle MDU operation.
  function automatic logic is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Divide-type START ops take the longer latency.
  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // MOVE_TO ops write HI/LO directly.
  function automatic logic is_move_to(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  // MOVE_FROM ops read HI/LO.
  function automatic logic is_move_from(input logic [3:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  // Any non-nop op touches the MDU and must respect its busy window.
  function automatic logic is_md(input logic [3:0] op);
    return op != MD_NOP;
  endfunction

endpackage

// File: rtl/md_busy_shadow.sv
// Cycle-exact shadow of the MDU busy window: a down-counter plus a small FSM
// that remembers which kind of operation is outstanding. Freezes under req the
// same way the MDU freezes its own counter.
module md_busy_shadow
  import md_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [CNT_W-1:0] i_latency,
  input  logic             i_req,
  output logic             o_pred_busy
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;

  // Busy is simply "not idle"; the counter is non-zero exactly when not idle.
  assign o_pred_busy = (r_state != ST_IDLE);

  // Load on issue, count down while not frozen, drop back to idle on 1->0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_cnt   <= i_latency;
            r_state <= i_is_div ? ST_DIV_WAIT : ST_MUL_WAIT;
          end
        end
        default: begin
          if (!i_req) begin
            // A latency of 0 or 1 still leaves after one cycle, never wraps.
            if (r_cnt <= CNT_W'(1)) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the multiply/divide unit: drives the MDU command bus,
// stalls MD-class instructions that meet a busy unit, and flags any
// disagreement between the MDU busy output and the local shadow.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_valid,
  input  logic [3:0]  e_mdop,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        md_busy,
  output logic        md_en,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        proto_err
);

  logic             w_pred_busy;
  logic             w_stall;
  logic             w_md_en;
  logic [CNT_W-1:0] w_latency;
  logic             r_proto_err;

  // Latency chosen from the op in E; only consumed when an issue happens.
  assign w_latency = is_div(e_mdop) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

  // Stall is not masked by req so D/E hold their contents across an exception
  // request that arrives while the unit is busy.
  assign w_stall = e_valid & is_md(e_mdop) & w_pred_busy;
  assign w_md_en = e_valid & is_start(e_mdop) & ~w_pred_busy & ~req;

  md_busy_shadow #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_md_en),
    .i_is_div    (is_div(e_mdop)),
    .i_latency   (w_latency),
    .i_req       (req),
    .o_pred_busy (w_pred_busy)
  );

  // Opcode is squashed to nop whenever the op must not take effect, which keeps
  // mthi/mtlo from writing HI/LO under a busy unit or during req.
  always_comb begin
    md_op = MD_NOP;
    if (e_valid && !w_stall && !req) begin
      md_op = e_mdop;
    end
  end

  assign md_en     = w_md_en;
  assign md_a      = e_rs;
  assign md_b      = e_rt;
  assign stall     = w_stall;
  assign proto_err = r_proto_err;

  // Sticky protocol error: any cycle where the MDU and the shadow disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if (md_busy != w_pred_busy) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed testbench for md_issue_ctrl. A small behavioural MDU supplies
// md_busy; each check is an immediate assertion against a hand-derived value.
module tb_md_issue_ctrl;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5;
  localparam logic [3:0] OP_MFLO = 4'd6;
  localparam logic [3:0] OP_MTHI = 4'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        e_valid;
  logic [3:0]  e_mdop;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        md_busy;
  logic        md_en;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        stall;
  logic        proto_err;

  logic [7:0]  mdu_cnt;
  logic        force_low;

  int n_cmp = 0;
  int n_err = 0;

  md_issue_ctrl #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .e_valid   (e_valid),
    .e_mdop    (e_mdop),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .md_busy   (md_busy),
    .md_en     (md_en),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .stall     (stall),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // Behavioural MDU busy counter (5 for mult, 10 for div, frozen by req).
  always @(posedge clk) begin
    if (reset) mdu_cnt <= 8'd0;
    else if (md_en) mdu_cnt <= ((md_op == OP_DIV) || (md_op == OP_DIVU)) ? 8'd10 : 8'd5;
    else if ((mdu_cnt != 8'd0) && !req) mdu_cnt <= mdu_cnt - 8'd1;
  end
  assign md_busy = (mdu_cnt != 8'd0) && !force_low;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_mdop = OP_NOP;
    e_rs = 32'd0; e_rt = 32'd0; force_low = 1'b0;

    // Reset held for two cycles.
    tick(); tick();
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_md_en",     32'(md_en),     32'd0);
    reset = 1'b0;

    // mult issue with rs=3, rt=-4; one-cycle enable, then 5 quiet busy cycles.
    e_valid = 1'b1; e_mdop = OP_MULT; e_rs = 32'd3; e_rt = 32'hFFFF_FFFC; #1;
    chk("t1_md_en", 32'(md_en), 32'd1);
    chk("t1_md_op", 32'(md_op), 32'(OP_MULT));
    chk("t1_md_a",  md_a,       32'd3);
    chk("t1_md_b",  md_b,       32'hFFFF_FFFC);
    chk("t1_stall", 32'(stall), 32'd0);
    tick();
    e_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t1_busy_md_en", 32'(md_en), 32'd0);
      chk("t1_busy_stall", 32'(stall), 32'd0);
      tick();
    end
    chk("t1_proto_err", 32'(proto_err), 32'd0);

    // div by zero at T, mfhi stalls T+1..T+10, passes at T+11.
    e_valid = 1'b1; e_mdop = OP_DIV; e_rs = 32'd100; e_rt = 32'd0; #1;
    chk("t2_md_en", 32'(md_en), 32'd1);
    chk("t2_md_op", 32'(md_op), 32'(OP_DIV));
    tick();
    e_mdop = OP_MFHI;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("t2_stall",    32'(stall), 32'd1);
      chk("t2_md_op_nop", 32'(md_op), 32'(OP_NOP));
      chk("t2_md_en",    32'(md_en), 32'd0);
      tick();
    end
    #1;
    chk("t2_mfhi_stall", 32'(stall), 32'd0);
    chk("t2_mfhi_op",    32'(md_op), 32'(OP_MFHI));
    chk("t2_mfhi_en",    32'(md_en), 32'd0);
    tick();

    // mult at T, mthi squashed T+1..T+5, forwarded at T+6.
    e_mdop = OP_MULT; #1;
    chk("t3_md_en", 32'(md_en), 32'd1);
    tick();
    e_mdop = OP_MTHI;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t3_mthi_nop",   32'(md_op), 32'(OP_NOP));
      chk("t3_mthi_stall", 32'(stall), 32'd1);
      tick();
    end
    #1;
    chk("t3_mthi_op",    32'(md_op), 32'(OP_MTHI));
    chk("t3_mthi_en",    32'(md_en), 32'd0);
    chk("t3_mthi_stall", 32'(stall), 32'd0);
    tick();
    e_valid = 1'b0;

    // divu at T, req on T+3..T+5: three frozen cycles, last busy cycle T+13.
    e_valid = 1'b1; e_mdop = OP_DIVU; #1;
    chk("t4_md_en", 32'(md_en), 32'd1);
    tick();
    e_valid = 1'b0;
    tick(); tick();
    req = 1'b1; e_valid = 1'b1; e_mdop = OP_MULT;
    for (int k = 3; k <= 5; k++) begin
      #1;
      chk("t4_req_md_en", 32'(md_en), 32'd0);
      chk("t4_req_stall", 32'(stall), 32'd1);
      chk("t4_req_md_op", 32'(md_op), 32'(OP_NOP));
      tick();
    end
    req = 1'b0; e_mdop = OP_MFLO;
    for (int k = 6; k <= 13; k++) begin
      #1;
      chk("t4_tail_stall", 32'(stall), 32'd1);
      tick();
    end
    #1;
    chk("t4_idle_stall", 32'(stall), 32'd0);
    chk("t4_idle_md_op", 32'(md_op), 32'(OP_MFLO));
    tick();
    // req in idle with a START op in E blocks issue.
    req = 1'b1; e_mdop = OP_MULT; #1;
    chk("t4_idle_req_md_en", 32'(md_en), 32'd0);
    chk("t4_idle_req_md_op", 32'(md_op), 32'(OP_NOP));
    chk("t4_idle_req_stall", 32'(stall), 32'd0);
    tick();
    req = 1'b0; e_valid = 1'b0;
    chk("t4_proto_err", 32'(proto_err), 32'd0);

    // div at T, reset at T+4, mult accepted right after reset drops.
    e_valid = 1'b1; e_mdop = OP_DIV; #1;
    chk("t5_md_en", 32'(md_en), 32'd1);
    tick();
    e_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; e_valid = 1'b1; e_mdop = OP_MULT; #1;
    chk("t5_post_rst_stall", 32'(stall), 32'd0);
    chk("t5_post_rst_md_en", 32'(md_en), 32'd1);
    tick();
    e_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_proto_err", 32'(proto_err), 32'd0);

    // mult at T, md_busy forced low at T+2 -> proto_err from T+3, sticky.
    e_valid = 1'b1; e_mdop = OP_MULT; #1;
    chk("t6_md_en", 32'(md_en), 32'd1);
    tick();
    e_valid = 1'b0;
    tick();
    force_low = 1'b1; #1;
    chk("t6_pe_before", 32'(proto_err), 32'd0);
    tick();
    force_low = 1'b0; #1;
    chk("t6_pe_set", 32'(proto_err), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    chk("t6_pe_sticky", 32'(proto_err), 32'd1);
    // e_valid low ignores a START opcode.
    e_mdop = OP_MULT; #1;
    chk("t6_inv_md_en", 32'(md_en), 32'd0);
    chk("t6_inv_md_op", 32'(md_op), 32'(OP_NOP));
    chk("t6_inv_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("t6_pe_cleared", 32'(proto_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
